// File: rtl/hazard_fwd_unit_pkg.sv
// ============================================================================
// hazard_fwd_unit_pkg : shared pipe types for the hazard/forwarding unit
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_fwd_unit_pkg;

  localparam int REG_W     = 5;
  localparam int STG_IDX_W = 4;
  localparam int MAX_XLEN  = 64;

  typedef logic [STG_IDX_W-1:0] stg_idx_t;
  typedef logic [REG_W-1:0]     creg_t;

  typedef struct packed {
    logic                en;
    logic [MAX_XLEN-1:0] data;
  } fwd_data_t;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// ============================================================================
// fwd_sel : per-source priority selector, youngest matching stage wins
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_sel
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int XLEN   = 64
) (
  input  logic [REG_W-1:0]         src_addr,
  input  logic                     src_en,
  input  logic [NSTAGE*REG_W-1:0]  stg_dst,
  input  logic [NSTAGE-1:0]        stg_wen,
  input  logic [NSTAGE-1:0]        stg_valid,
  input  logic [NSTAGE*XLEN-1:0]   stg_data,
  output logic                     fwd_en,
  output logic [XLEN-1:0]          fwd_data,
  output logic                     hit,
  output logic                     pend
);

  logic [NSTAGE-1:0] match;
  logic              sel_valid;
  logic [XLEN-1:0]   sel_data;
  fwd_data_t         res;

  always_comb begin
    match     = '0;
    hit       = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    res       = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      match[k] = src_en & stg_wen[k] & (stg_dst[k*REG_W +: REG_W] == src_addr)
                 & (src_addr != '0);
    end
    // Walk oldest to youngest so the youngest match overwrites; an unready
    // youngest match hides older ready ones by design.
    for (int k = NSTAGE-1; k >= 0; k--) begin
      if (match[k]) begin
        hit       = 1'b1;
        sel_valid = stg_valid[k];
        sel_data  = stg_data[k*XLEN +: XLEN];
      end
    end
    if (hit && sel_valid) begin
      res.en   = 1'b1;
      res.data = MAX_XLEN'(sel_data);
    end
  end

  assign fwd_en   = res.en;
  assign fwd_data = res.data[XLEN-1:0];
  assign pend     = hit & ~sel_valid;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : operand forwarding, multi-cycle scoreboard, stall stats
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int NSTAGE      = 3,
  parameter int XLEN        = 64,
  parameter int STALL_LIMIT = 255,
  parameter int CNTW        = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*REG_W-1:0]    src_addr,
  input  logic [NSRC-1:0]          src_en,
  input  logic [NSTAGE*REG_W-1:0]  stg_dst,
  input  logic [NSTAGE-1:0]        stg_wen,
  input  logic [NSTAGE-1:0]        stg_valid,
  input  logic [NSTAGE*XLEN-1:0]   stg_data,
  input  logic                     mc_issue,
  input  logic [REG_W-1:0]         mc_dst,
  input  logic                     mc_done,
  input  logic [REG_W-1:0]         mc_done_dst,
  output logic [NSRC-1:0]          fwd_en,
  output logic [NSRC*XLEN-1:0]     fwd_data,
  output logic                     stall,
  output logic [31:0]              busy_vec,
  output logic [CNTW-1:0]          stall_cycles,
  output logic                     deadlock
);

  localparam int RUNW = $clog2(STALL_LIMIT + 1);
  localparam logic [RUNW-1:0] RUN_MAX = RUNW'(STALL_LIMIT);

  logic [NSRC-1:0] src_hit;
  logic [NSRC-1:0] src_pend;
  logic [31:0]     busy_eff;
  logic [31:0]     busy_nxt;
  logic [RUNW-1:0] run_cnt;
  logic [RUNW-1:0] run_nxt;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_sel #(
      .NSTAGE (NSTAGE),
      .XLEN   (XLEN)
    ) u_fwd_sel (
      .src_addr  (src_addr[i*REG_W +: REG_W]),
      .src_en    (src_en[i]),
      .stg_dst   (stg_dst),
      .stg_wen   (stg_wen),
      .stg_valid (stg_valid),
      .stg_data  (stg_data),
      .fwd_en    (fwd_en[i]),
      .fwd_data  (fwd_data[i*XLEN +: XLEN]),
      .hit       (src_hit[i]),
      .pend      (src_pend[i])
    );
  end

  always_comb begin
    busy_eff = busy_vec;
    if (mc_done) busy_eff[mc_done_dst] = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      stall = stall | src_pend[i]
            | (src_en[i] & busy_eff[src_addr[i*REG_W +: REG_W]] & ~src_hit[i]);
    end
  end

  // Completion clears before issue sets, so a same-register reissue stays busy.
  always_comb begin
    busy_nxt = busy_vec;
    if (mc_done)  busy_nxt[mc_done_dst] = 1'b0;
    if (mc_issue) busy_nxt[mc_dst]      = 1'b1;
    busy_nxt[0] = 1'b0;
    run_nxt = '0;
    if (stall) run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec     <= '0;
      stall_cycles <= '0;
      run_cnt      <= '0;
      deadlock     <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      run_cnt  <= run_nxt;
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (run_nxt == RUN_MAX) deadlock <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// ============================================================================
// tb_hazard_fwd_unit : scoreboard-driven bench for hazard_fwd_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   src_addr;
  logic [1:0]   src_en;
  logic [14:0]  stg_dst;
  logic [2:0]   stg_wen;
  logic [2:0]   stg_valid;
  logic [191:0] stg_data;
  logic         mc_issue;
  logic [4:0]   mc_dst;
  logic         mc_done;
  logic [4:0]   mc_done_dst;
  logic [1:0]   fwd_en;
  logic [127:0] fwd_data;
  logic         stall;
  logic [31:0]  busy_vec;
  logic [31:0]  stall_cycles;
  logic         deadlock;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t q[$];
  sb_t e;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NSRC(2), .NSTAGE(3), .XLEN(64), .STALL_LIMIT(4), .CNTW(32)
  ) dut (
    .clk(clk), .reset(reset), .src_addr(src_addr), .src_en(src_en),
    .stg_dst(stg_dst), .stg_wen(stg_wen), .stg_valid(stg_valid),
    .stg_data(stg_data), .mc_issue(mc_issue), .mc_dst(mc_dst),
    .mc_done(mc_done), .mc_done_dst(mc_done_dst), .fwd_en(fwd_en),
    .fwd_data(fwd_data), .stall(stall), .busy_vec(busy_vec),
    .stall_cycles(stall_cycles), .deadlock(deadlock)
  );

  task automatic idle();
    src_addr = '0; src_en = '0; stg_dst = '0; stg_wen = '0;
    stg_valid = '0; stg_data = '0; mc_issue = 1'b0; mc_dst = '0;
    mc_done = 1'b0; mc_done_dst = '0;
  endtask

  task automatic set_stage(input int k, input logic [4:0] dst, input logic wen,
                           input logic vld, input logic [63:0] data);
    stg_dst[k*5 +: 5]    = dst;
    stg_wen[k]           = wen;
    stg_valid[k]         = vld;
    stg_data[k*64 +: 64] = data;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    q.push_back('{"rst_busy", 64'd0});
    q.push_back('{"rst_cycles", 64'd0});
    q.push_back('{"rst_deadlock", 64'd0});
    q.push_back('{"rst_fwd_en", 64'd0});
    e = q.pop_front(); vectors++;
    if (64'(busy_vec) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(stall_cycles) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall_cycles, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(deadlock) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, deadlock, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(fwd_en) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_en, e.exp); end
  endtask

  task automatic test_priority();
    @(negedge clk); idle();
    src_addr = {5'd6, 5'd5}; src_en = 2'b11;
    set_stage(0, 5'd5, 1'b1, 1'b1, 64'h11);
    set_stage(1, 5'd6, 1'b1, 1'b1, 64'h22);
    set_stage(2, 5'd5, 1'b1, 1'b1, 64'h33);
    q.push_back('{"prio_fwd_en", 64'd3});
    q.push_back('{"prio_data0", 64'h11});
    q.push_back('{"prio_data1", 64'h22});
    q.push_back('{"prio_stall", 64'd0});
    #2;
    e = q.pop_front(); vectors++;
    if (64'(fwd_en) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_en, e.exp); end
    e = q.pop_front(); vectors++;
    if (fwd_data[63:0] !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_data[63:0], e.exp); end
    e = q.pop_front(); vectors++;
    if (fwd_data[127:64] !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_data[127:64], e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(stall) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall, e.exp); end
    // No match on src0 (x8) and x0 on src1 even though stage 0 writes x0.
    src_addr = {5'd0, 5'd8};
    set_stage(0, 5'd0, 1'b1, 1'b1, 64'h44);
    q.push_back('{"nomatch_fwd_en", 64'd0});
    q.push_back('{"nomatch_data", 128'd0 == 0 ? 64'd0 : 64'd1});
    #1;
    e = q.pop_front(); vectors++;
    if (64'(fwd_en) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_en, e.exp); end
    e = q.pop_front(); vectors++;
    if ((fwd_data[63:0] | fwd_data[127:64]) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_data, e.exp); end
  endtask

  task automatic test_load_stall();
    @(negedge clk); idle();
    src_addr = {5'd0, 5'd7}; src_en = 2'b01;
    set_stage(0, 5'd7, 1'b1, 1'b0, 64'h11);
    set_stage(1, 5'd7, 1'b1, 1'b1, 64'h22);
    q.push_back('{"load_fwd_en", 64'd0});
    q.push_back('{"load_stall", 64'd1});
    q.push_back('{"load_dis_stall", 64'd0});
    #2;
    e = q.pop_front(); vectors++;
    if (64'(fwd_en) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_en, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(stall) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall, e.exp); end
    src_en = 2'b00; #1;
    e = q.pop_front(); vectors++;
    if (64'(stall) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall, e.exp); end
  endtask

  task automatic test_multicycle();
    @(negedge clk); idle(); mc_issue = 1'b1; mc_dst = 5'd9;
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); idle(); src_addr = {5'd0, 5'd9}; src_en = 2'b01;
      q.push_back('{"mc_wait_stall", 64'd1});
      q.push_back('{"mc_wait_busy", 64'd1});
      #2;
      e = q.pop_front(); vectors++;
      if (64'(stall) !== e.exp) begin miscompares++; $display("FAIL %s c%0d got %h want %h", e.tag, c, stall, e.exp); end
      e = q.pop_front(); vectors++;
      if (64'(busy_vec[9]) !== e.exp) begin miscompares++; $display("FAIL %s c%0d got %h want %h", e.tag, c, busy_vec[9], e.exp); end
    end
    @(negedge clk);
    mc_done = 1'b1; mc_done_dst = 5'd9;
    set_stage(0, 5'd9, 1'b1, 1'b1, 64'h99);
    q.push_back('{"mc_done_stall", 64'd0});
    q.push_back('{"mc_done_data", 64'h99});
    q.push_back('{"mc_cleared", 64'd0});
    #2;
    e = q.pop_front(); vectors++;
    if (64'(stall) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall, e.exp); end
    e = q.pop_front(); vectors++;
    if ((fwd_en[0] ? fwd_data[63:0] : 64'hdead) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, fwd_data[63:0], e.exp); end
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(busy_vec[9]) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec[9], e.exp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); idle(); mc_issue = 1'b1; mc_dst = 5'd0;
    q.push_back('{"x0_issue_busy", 64'd0});
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(busy_vec) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec, e.exp); end
    @(negedge clk); idle(); mc_issue = 1'b1; mc_dst = 5'd3;
    q.push_back('{"issue3_busy", 64'h8});
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(busy_vec) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec, e.exp); end
    @(negedge clk); idle(); mc_issue = 1'b1; mc_dst = 5'd3; mc_done = 1'b1; mc_done_dst = 5'd3;
    q.push_back('{"same_cycle_busy", 64'h8});
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(busy_vec) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec, e.exp); end
    @(negedge clk); idle(); mc_done = 1'b1; mc_done_dst = 5'd3;
    q.push_back('{"done3_busy", 64'd0});
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(busy_vec) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, busy_vec, e.exp); end
  endtask

  task automatic test_deadlock();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); idle();
      src_addr = {5'd0, 5'd7}; src_en = 2'b01;
      set_stage(0, 5'd7, 1'b1, 1'b0, 64'h0);
      @(posedge clk); #1;
      if (c == 3) begin
        q.push_back('{"dl_early", 64'd0});
        e = q.pop_front(); vectors++;
        if (64'(deadlock) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, deadlock, e.exp); end
      end
    end
    q.push_back('{"dl_set", 64'd1});
    q.push_back('{"dl_cycles", 64'd4});
    q.push_back('{"dl_held", 64'd1});
    q.push_back('{"dl_cycles_held", 64'd4});
    e = q.pop_front(); vectors++;
    if (64'(deadlock) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, deadlock, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(stall_cycles) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall_cycles, e.exp); end
    @(negedge clk); idle();
    @(posedge clk); #1;
    e = q.pop_front(); vectors++;
    if (64'(deadlock) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, deadlock, e.exp); end
    e = q.pop_front(); vectors++;
    if (64'(stall_cycles) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, stall_cycles, e.exp); end
    do_reset();
    q.push_back('{"dl_reset", 64'd0});
    e = q.pop_front(); vectors++;
    if (64'({deadlock, stall_cycles}) !== e.exp) begin miscompares++; $display("FAIL %s got %h want %h", e.tag, {deadlock, stall_cycles}, e.exp); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_priority();
    test_load_stall();
    test_multicycle();
    test_back_to_back();
    test_deadlock();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter NSRC, default 2: number of source operands checked per cycle.
REQ-002 SHALL have parameter NSTAGE, default 3: forwarding stages; index 0 is youngest (E), then M, then W.
REQ-003 SHALL have parameter XLEN, default 64: data width.
REQ-004 SHALL have parameter STALL_LIMIT, default 255: consecutive-stall cycles that trip the deadlock flag.
REQ-005 SHALL have parameter CNTW, default 32: width of the stall statistics counter.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 src_addr  in  NSRC x 5  register index of each source operand in decode.
REQ-009 src_en  in  NSRC  source actually read this cycle.
REQ-010 stg_dst  in  NSTAGE x 5  destination register per stage.
REQ-011 stg_wen  in  NSTAGE  stage will write its destination.
REQ-012 stg_valid  in  NSTAGE  stage result already available (0 = load still in flight).
REQ-013 stg_data  in  NSTAGE x XLEN  stage result.
REQ-014 mc_issue / mc_dst  in  1 / 5  a multi-cycle op (mul/div) targeting mc_dst is issued.
REQ-015 mc_done / mc_done_dst  in  1 / 5  a multi-cycle op completes; its result is in stage 0 this cycle.
REQ-016 fwd_en / fwd_data  out  NSRC / NSRC x XLEN  forward valid and forwarded value per source.
REQ-017 stall  out  1  decode must hold this cycle.
REQ-018 busy_vec  out  32  registered scoreboard, one bit per register.
REQ-019 stall_cycles  out  CNTW  saturating count of cycles with stall=1.
REQ-020 deadlock  out  1  sticky flag for a run of too many consecutive stalls.

Function
REQ-021 SHALL set, per source, match[k] = src_en & stg_wen[k] & (stg_dst[k] == src_addr) & (src_addr != 0).
REQ-022 SHALL select the lowest k with match[k]; fwd_en=1 and fwd_data=stg_data[k] only if stg_valid[k]=1.
REQ-023 SHALL, when the selected stage has stg_valid=0, set fwd_en=0 and raise stall, never falling back to an older stage.
REQ-024 SHALL, with no match, set fwd_en=0 and fwd_data=0.
REQ-025 SHALL treat register x0 as never forwarded and never busy.
REQ-026 SHALL form busy_eff = busy_vec with the bit for mc_done_dst masked when mc_done=1 (done bypass).
REQ-027 SHALL raise stall when an enabled source has busy_eff set and no stage match.
REQ-028 SHALL compute stall and forwarding combinationally, with zero-cycle latency from inputs and the registered busy_vec.
REQ-029 SHALL update the scoreboard each edge: mc_done clears bit mc_done_dst, then mc_issue sets bit mc_dst; issue wins when both hit the same register.
REQ-030 SHALL ignore mc_issue and mc_done for x0; repeated issue to an already-busy register keeps the bit at 1.
REQ-031 SHALL increment stall_cycles on each cycle with stall=1 and saturate at all-ones.
REQ-032 SHALL keep a consecutive-stall run counter that clears on any stall=0 cycle and saturates at STALL_LIMIT.
REQ-033 SHALL set deadlock when the run counter reaches STALL_LIMIT; deadlock then holds until reset.

Reset
REQ-034 SHALL, with reset=1 at an edge, clear busy_vec, stall_cycles, the run counter and deadlock to 0; reset has priority over mc_issue.
REQ-035 SHALL keep the combinational outputs driven from inputs during reset; reset mid multi-cycle op drops all pending busy bits.

Structure
REQ-036 SHALL place the stage-index typedef, creg address type and the fwd_data_t enable+data struct in the shared pipes package.
REQ-037 SHALL use one sub-module, fwd_sel: a per-source priority selector instantiated NSRC times via generate.
REQ-038 SHALL keep all state (scoreboard, counters, deadlock flag) in hazard_fwd_unit.

Verification
REQ-039 src_addr[0]=5; stg 0 and 2 both write x5, valid, data 0x11/0x33 -> fwd_data[0]=0x11, stall=0.
REQ-040 stg0 writes x7 with valid=0; stg1 writes x7 valid data 0x22; src=7 -> fwd_en=0, stall=1.
REQ-041 mc_issue x9 at cycle 0; src=9 for cycles 1-4 -> stall=1; mc_done x9 at cycle 5 with stg0 x9 valid -> stall=0, forwarded; busy_vec[9]=0 at cycle 6.
REQ-042 Same-cycle mc_done x3 and mc_issue x3 -> busy_vec[3]=1 next cycle; mc_issue x0 -> busy_vec stays 0.
REQ-043 With STALL_LIMIT=4, hold stall 4 cycles -> deadlock=1 and stays 1 after stall drops; stall_cycles=4; reset -> all 0.
